// File: rtl/score_disp_mux_pkg.sv
// Shared constants and types for the score display multiplexer.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package score_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef logic [1:0] slot_t;

  typedef enum logic {FL_IDLE, FL_FLASH} flash_state_t;

endpackage

// File: rtl/score_disp_mux_flash.sv
// Per-player flash engine: after an increment pulse, alternates blank/visible
// half-periods of BLINK_DIV cycles, starting blank, for FLASH_TOGGLES halves.
//
// state    | meaning
// FL_IDLE  | digits shown normally
// FL_FLASH | flashing; blank while tcnt is even
module score_flash
  import score_disp_pkg::*;
#(
  parameter int BLINK_DIV     = 25000000,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic blank
);

  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = $clog2(FLASH_TOGGLES + 1);

  localparam logic [PW-1:0] PHASE_LOAD = PW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(FLASH_TOGGLES - 1);

  flash_state_t    state;
  logic [PW-1:0]   pcnt;
  logic [TW-1:0]   tcnt;

  // Phase timer is a down-counter; a retrigger reloads it so the new
  // sequence starts with a full blank half-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FL_IDLE;
      pcnt  <= '0;
      tcnt  <= '0;
    end else if (inc) begin
      state <= FL_FLASH;
      pcnt  <= PHASE_LOAD;
      tcnt  <= '0;
    end else if (state == FL_FLASH) begin
      if (pcnt == '0) begin
        pcnt <= PHASE_LOAD;
        tcnt <= tcnt + 1'b1;
        if (tcnt == TCNT_LAST) state <= FL_IDLE;
      end else begin
        pcnt <= pcnt - 1'b1;
      end
    end
  end

  assign blank = (state == FL_FLASH) && !tcnt[0];

endmodule

// File: rtl/score_disp_mux_seg7_decode.sv
// BCD to 7-segment decoder, active-high. Non-BCD codes render as a dash.
module seg7_decode
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_disp_mux.sv
// Time-multiplexed 4-digit 7-segment driver for the two-player score.
// Slots 3/2 = left tens/units, slots 1/0 = right tens/units.
module score_disp_mux
  import score_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int GHOST         = 2000,
  parameter int BLINK_DIV     = 25000000,
  parameter int FLASH_TOGGLES = 6,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic       l_d_inc,
  input  logic       r_d_inc,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] GHOST_END = RW'(GHOST);
  localparam logic          INV       = (ACTIVE_LOW != 0);

  logic [RW-1:0]       rcnt;
  slot_t               slot;
  logic [3:0][3:0]     sh;
  logic                wrap;

  logic [3:0]          cur_dig;
  logic [6:0]          dec_seg;
  logic                blank_l;
  logic                blank_r;
  logic                blank;
  logic [3:0]          an_next;
  logic [6:0]          seg_next;
  logic                dp_next;

  assign wrap = (rcnt == RCNT_LAST);

  // Shadow digits only update when entering slot 0 so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      slot <= '0;
      sh   <= '0;
    end else if (wrap) begin
      rcnt <= '0;
      slot <= slot + 2'd1;
      if (slot == 2'd3) sh <= {dig3, dig2, dig1, dig0};
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  score_flash #(
    .BLINK_DIV     (BLINK_DIV),
    .FLASH_TOGGLES (FLASH_TOGGLES)
  ) u_flash_l (
    .clk   (clk),
    .reset (reset),
    .inc   (l_d_inc),
    .blank (blank_l)
  );

  score_flash #(
    .BLINK_DIV     (BLINK_DIV),
    .FLASH_TOGGLES (FLASH_TOGGLES)
  ) u_flash_r (
    .clk   (clk),
    .reset (reset),
    .inc   (r_d_inc),
    .blank (blank_r)
  );

  assign cur_dig = sh[slot];

  seg7_decode u_dec (
    .bcd (cur_dig),
    .seg (dec_seg)
  );

  always_comb begin
    blank    = (blank_lz && slot[0] && (cur_dig == 4'd0)) ||
               (slot[1] ? blank_l : blank_r);
    seg_next = blank ? SEG_OFF : dec_seg;
    dp_next  = (slot == 2'd2) && !blank;
    an_next  = (rcnt < GHOST_END) ? 4'b0000 : (4'b0001 << slot);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= {4{INV}};
      seg <= {7{INV}};
      dp  <= INV;
    end else begin
      an  <= an_next  ^ {4{INV}};
      seg <= seg_next ^ {7{INV}};
      dp  <= dp_next  ^ INV;
    end
  end

endmodule

// File: tb/tb_score_disp_mux.sv
// Self-checking bench for score_disp_mux with a time-based reference model.
module tb_score_disp_mux;

  localparam int RD = 8;
  localparam int GH = 2;
  localparam int BD = 16;
  localparam int FT = 4;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dig0 = '0, dig1 = '0, dig2 = '0, dig3 = '0;
  logic       l_d_inc = 1'b0, r_d_inc = 1'b0, blank_lz = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int passed = 0;
  int total  = 0;

  score_disp_mux #(
    .REFRESH_DIV   (RD),
    .GHOST         (GH),
    .BLINK_DIV     (BD),
    .FLASH_TOGGLES (FT),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dig0     (dig0),
    .dig1     (dig1),
    .dig2     (dig2),
    .dig3     (dig3),
    .l_d_inc  (l_d_inc),
    .r_d_inc  (r_d_inc),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // Reference model: m_t = clock edges since reset; scan position, frame
  // latching and flash phase are all derived from elapsed time.
  logic [6:0] dec_tab [16];
  initial begin
    dec_tab[0] = 7'h3F; dec_tab[1] = 7'h06; dec_tab[2] = 7'h5B; dec_tab[3] = 7'h4F;
    dec_tab[4] = 7'h66; dec_tab[5] = 7'h6D; dec_tab[6] = 7'h7D; dec_tab[7] = 7'h07;
    dec_tab[8] = 7'h7F; dec_tab[9] = 7'h6F;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'h40;
  end

  int         m_t;
  int         m_sh [4];
  bit         l_act, r_act;
  int         l_age, r_age;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 0;
      l_act = 0; r_act = 0; l_age = 0; r_age = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      int  s, d;
      bit  lb, rb, blk;
      s  = (m_t / RD) % 4;
      d  = m_sh[s];
      lb = l_act && ((l_age / BD) % 2 == 0);
      rb = r_act && ((r_age / BD) % 2 == 0);
      blk = (blank_lz && (s == 1 || s == 3) && d == 0) || ((s >= 2) ? lb : rb);
      exp_an  = ((m_t % RD) < GH) ? 4'hF : ~(4'b0001 << s);
      exp_seg = blk ? 7'h7F : ~dec_tab[d];
      exp_dp  = !((s == 2) && !blk);
      if (m_t % FRAME == FRAME - 1) begin
        m_sh[0] = int'(dig0); m_sh[1] = int'(dig1);
        m_sh[2] = int'(dig2); m_sh[3] = int'(dig3);
      end
      if (l_d_inc) begin l_act = 1; l_age = 0; end
      else if (l_act) begin l_age++; if (l_age >= FT * BD) l_act = 0; end
      if (r_d_inc) begin r_act = 1; r_age = 0; end
      else if (r_act) begin r_age++; if (r_age >= FT * BD) r_act = 0; end
      m_t++;
    end
  end

  task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
    dig3 = 4'(d3); dig2 = 4'(d2); dig1 = 4'(d1); dig0 = 4'(d0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_digits(0, 0, 0, 0);
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      $display("FAIL reset_hold: an=%h seg=%h dp=%b want an=f seg=7f dp=1", an, seg, dp);
    end else passed++;
    reset = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL reset_scan t=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_t, an, seg, dp, exp_an, exp_seg, exp_dp);
      else passed++;
    end
  endtask

  task automatic test_digits();
    set_digits(1, 2, 3, 4);
    blank_lz = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL digits t=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_t, an, seg, dp, exp_an, exp_seg, exp_dp);
      else passed++;
      // Fixed check on slot 2 once the 1,2,3,4 frame is showing.
      if (k >= FRAME && an == 4'b1011) begin
        total++;
        if ({seg, dp} !== {7'h24, 1'b0})
          $display("FAIL digits_slot2: seg=%h dp=%b want seg=24 dp=0", seg, dp);
        else passed++;
      end
    end
  endtask

  task automatic test_blank_lz();
    set_digits(0, 5, 0, 7);
    blank_lz = 1'b1;
    while ((m_t % FRAME) != 0) @(negedge clk);
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      if (k == FRAME + 12) dig0 = 4'd9;
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL blank_lz t=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_t, an, seg, dp, exp_an, exp_seg, exp_dp);
      else passed++;
    end
  endtask

  task automatic test_dash();
    set_digits(0, 5, 12, 7);
    blank_lz = 1'b1;
    for (int k = 0; k < 2 * FRAME + 4; k++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL dash t=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_t, an, seg, dp, exp_an, exp_seg, exp_dp);
      else passed++;
      if (k >= FRAME + 2 && an == 4'b1101) begin
        total++;
        if (seg !== 7'h3F) $display("FAIL dash_slot1: seg=%h want 3f", seg);
        else passed++;
      end
    end
  endtask

  task automatic test_flash();
    set_digits(8, 8, 8, 8);
    blank_lz = 1'b0;
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL flash t=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_t, an, seg, dp, exp_an, exp_seg, exp_dp);
      else passed++;
      l_d_inc = (k == 0) || (k == 20) || (k == 140);
      r_d_inc = (k == 140);
    end
    l_d_inc = 1'b0;
    r_d_inc = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard;
    l_d_inc = 1'b1;
    @(negedge clk);
    l_d_inc = 1'b0;
    guard = 0;
    while ((m_t % FRAME) != 2 * RD + 4 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 2 * FRAME) $display("FAIL reset_mid_wait: guard=%0d want <%0d", guard, 2 * FRAME);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1})
      $display("FAIL reset_mid_async: an=%h seg=%h dp=%b want an=f seg=7f dp=1", an, seg, dp);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL reset_mid_after t=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_t, an, seg, dp, exp_an, exp_seg, exp_dp);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      total++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp})
        $display("FAIL random t=%0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 m_t, an, seg, dp, exp_an, exp_seg, exp_dp);
      else passed++;
      if ($urandom_range(0, 15) == 0)
        set_digits($urandom_range(0, 15), $urandom_range(0, 9),
                   $urandom_range(0, 15), $urandom_range(0, 9));
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      l_d_inc = ($urandom_range(0, 99) == 0);
      r_d_inc = ($urandom_range(0, 99) == 0);
    end
    l_d_inc = 1'b0;
    r_d_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_digits();
    test_blank_lz();
    test_dash();
    test_flash();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
